// File: rtl/bus_timer_if.sv
// -----------------------------------------------------------------------------
// bus_timer_if
//   MemSplit32 register-access bundle between a bus master and the timer.
//   Signals:
//     bus_req_i    : request, already address-decoded by the top level
//     bus_ack_o    : request accepted
//     bus_addr_bi  : byte address (timer decodes [3:2] only)
//     bus_we_i     : 1 = write, 0 = read
//     bus_wdata_bi : write data
//     bus_be_bi    : byte enables for writes
//     bus_resp_o   : read response valid (one cycle)
//     bus_rdata_bo : read data, 0 when no response
//   Modports: master (drives request side), slave (the timer).
// -----------------------------------------------------------------------------
interface bus_timer_if;
    logic        bus_req_i;
    logic        bus_ack_o;
    logic [31:0] bus_addr_bi;
    logic        bus_we_i;
    logic [31:0] bus_wdata_bi;
    logic [3:0]  bus_be_bi;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;

    modport master (
        output bus_req_i, bus_addr_bi, bus_we_i, bus_wdata_bi, bus_be_bi,
        input  bus_ack_o, bus_resp_o, bus_rdata_bo
    );

    modport slave (
        input  bus_req_i, bus_addr_bi, bus_we_i, bus_wdata_bi, bus_be_bi,
        output bus_ack_o, bus_resp_o, bus_rdata_bo
    );
endinterface

// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
//   Memory-mapped up-counting timer with prescaler, one-shot / auto-reload
//   modes and a sticky expiry flag driving a level interrupt.
//   Parameter:
//     PRESCALE : clk_gen cycles per counter tick (1..65535)
//   Ports:
//     clk_gen  : clock, rising edge
//     srst     : synchronous active-high reset
//     bus      : bus_timer_if.slave register-access port
//     irq_o    : EXPIRED & IRQ_EN (registered state only)
//   Register map (addr[3:2]):
//     0 CTRL   : bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN
//     1 PERIOD : 32-bit RW
//     2 COUNT  : 32-bit RW
//     3 STATUS : bit0 EXPIRED, write-1-to-clear
// -----------------------------------------------------------------------------
module bus_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk_gen,
    input  logic        srst,
    bus_timer_if.slave  bus,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        SEL_CTRL   = 2'd0,
        SEL_PERIOD = 2'd1,
        SEL_COUNT  = 2'd2,
        SEL_STATUS = 2'd3
    } reg_sel_e;

    localparam logic [15:0] DIV_LAST = 16'(PRESCALE - 1);

    logic        en_q, en_d;
    logic        autoreload_q, autoreload_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] period_q, period_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] div_q, div_d;
    logic        resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;

    reg_sel_e    sel;
    logic        rd, wr;
    logic        ctrl_wr, period_wr, count_wr, status_clr;
    logic        tick, expire;
    logic [31:0] read_val;

    // Only addr[3:2] selects a register; the rest of the address is don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.bus_addr_bi[31:4], bus.bus_addr_bi[1:0]};

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // The timer never stalls.
    assign bus.bus_ack_o = bus.bus_req_i;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        sel        = reg_sel_e'(bus.bus_addr_bi[3:2]);
        rd         = bus.bus_req_i & ~bus.bus_we_i;
        wr         = bus.bus_req_i &  bus.bus_we_i;
        ctrl_wr    = wr && (sel == SEL_CTRL);
        period_wr  = wr && (sel == SEL_PERIOD);
        count_wr   = wr && (sel == SEL_COUNT);
        status_clr = wr && (sel == SEL_STATUS) && bus.bus_be_bi[0] && bus.bus_wdata_bi[0];

        tick   = en_q && (div_q == DIV_LAST);
        // A COUNT write suppresses expiry evaluation in the same cycle.
        expire = tick && !count_wr && (count_q == period_q);

        read_val = '0;
        unique case (sel)
            SEL_CTRL:   read_val = {29'd0, irq_en_q, autoreload_q, en_q};
            SEL_PERIOD: read_val = period_q;
            SEL_COUNT:  read_val = count_q;
            SEL_STATUS: read_val = {31'd0, expired_q};
        endcase

        // Divider restarts on disable, on a COUNT write and after each tick.
        div_d = div_q + 16'd1;
        if (!en_q || count_wr || tick) div_d = '0;

        count_d = count_q;
        if (count_wr) begin
            count_d = be_merge(count_q, bus.bus_wdata_bi, bus.bus_be_bi);
        end else if (expire) begin
            if (autoreload_q) count_d = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end

        en_d         = en_q;
        autoreload_d = autoreload_q;
        irq_en_d     = irq_en_q;
        if (expire && !autoreload_q) en_d = 1'b0;
        // A CTRL write lands after the one-shot clear so software wins for EN.
        if (ctrl_wr && bus.bus_be_bi[0]) begin
            en_d         = bus.bus_wdata_bi[0];
            autoreload_d = bus.bus_wdata_bi[1];
            irq_en_d     = bus.bus_wdata_bi[2];
        end

        period_d = period_q;
        if (period_wr) period_d = be_merge(period_q, bus.bus_wdata_bi, bus.bus_be_bi);

        // Set has priority over the W1C clear.
        expired_d = expired_q;
        if (status_clr) expired_d = 1'b0;
        if (expire)     expired_d = 1'b1;

        resp_d  = rd;
        rdata_d = rd ? read_val : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and overrides all updates.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            en_q         <= 1'b0;
            autoreload_q <= 1'b0;
            irq_en_q     <= 1'b0;
            period_q     <= '0;
            count_q      <= '0;
            expired_q    <= 1'b0;
            div_q        <= '0;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            en_q         <= en_d;
            autoreload_q <= autoreload_d;
            irq_en_q     <= irq_en_d;
            period_q     <= period_d;
            count_q      <= count_d;
            expired_q    <= expired_d;
            div_q        <= div_d;
            resp_q       <= resp_d;
            rdata_q      <= rdata_d;
        end
    end

    // A response already registered when srst rises must not escape.
    assign bus.bus_resp_o   = resp_q & ~srst;
    assign bus.bus_rdata_bo = srst ? 32'd0 : rdata_q;

    assign irq_o = expired_q & irq_en_q;

endmodule
